// File: rtl/uart_param.sv
// Parametrised full-duplex UART with a shared oversampling baud tick.
// Define UART_PARITY_EN to add one parity bit per frame (PARITY_ODD selects sense).
module uart_param #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_div_chk
    $error("uart_param: clock too slow, DIV must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_chk
    $error("uart_param: illegal frame configuration");
  end

  localparam logic [2:0] T_IDLE  = 3'd0;
  localparam logic [2:0] T_SYNC  = 3'd1;
  localparam logic [2:0] T_START = 3'd2;
  localparam logic [2:0] T_DATA  = 3'd3;
  localparam logic [2:0] T_STOP  = 3'd5;

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd4;
  localparam logic [2:0] R_WAIT  = 3'd5;

`ifdef UART_PARITY_EN
  localparam logic [2:0] T_PAR = 3'd4;
  localparam logic [2:0] R_PAR = 3'd3;
  localparam logic       ODD   = 1'(PARITY_ODD);
  logic tpar;
  logic rpe;
`endif

  logic [CW-1:0] bcnt;
  logic          tick;

  assign tick = (bcnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bcnt <= '0;
    else      bcnt <= tick ? '0 : bcnt + 1'b1;
  end

  logic [2:0]           tstate;
  logic [TW-1:0]        ttk;
  logic [BW-1:0]        tbit;
  logic [DATA_BITS-1:0] tsh;
  logic                 tlast;

  assign tlast = tick && (ttk == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tstate  <= T_IDLE;
      ttk     <= '0;
      tbit    <= '0;
      tsh     <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_PARITY_EN
      tpar    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (tick) ttk <= tlast ? '0 : ttk + 1'b1;
      unique case (tstate)
        T_IDLE: if (tx_start) begin
          tsh     <= tx_data;
          tx_busy <= 1'b1;
          tstate  <= T_SYNC;
`ifdef UART_PARITY_EN
          tpar    <= (^tx_data) ^ ODD;
`endif
        end
        // start bit begins on a tick so every bit is a whole tick multiple
        T_SYNC: if (tick) begin
          tx     <= 1'b0;
          ttk    <= '0;
          tstate <= T_START;
        end
        T_START: if (tlast) begin
          tx     <= tsh[0];
          tsh    <= tsh >> 1;
          tbit   <= '0;
          tstate <= T_DATA;
        end
        T_DATA: if (tlast) begin
          if (tbit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            tx     <= tpar;
            tstate <= T_PAR;
`else
            tx     <= 1'b1;
            tbit   <= '0;
            tstate <= T_STOP;
`endif
          end else begin
            tx   <= tsh[0];
            tsh  <= tsh >> 1;
            tbit <= tbit + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        T_PAR: if (tlast) begin
          tx     <= 1'b1;
          tbit   <= '0;
          tstate <= T_STOP;
        end
`endif
        T_STOP: if (tlast) begin
          if (tbit == BW'(STOP_BITS - 1)) begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            tstate  <= T_IDLE;
          end else begin
            tbit <= tbit + 1'b1;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end

  logic [1:0]           rsync;
  logic                 rs;
  logic [2:0]           rstate;
  logic [TW-1:0]        rtk;
  logic [BW-1:0]        rbit;
  logic [DATA_BITS-1:0] rsh;
  logic                 rlast;
  logic                 rhalf;

  assign rs    = rsync[1];
  assign rlast = tick && (rtk == TW'(OVERSAMPLE - 1));
  assign rhalf = tick && (rtk == TW'(OVERSAMPLE / 2 - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsync        <= 2'b11;
      rstate       <= R_IDLE;
      rtk          <= '0;
      rbit         <= '0;
      rsh          <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rpe           <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rsync    <= {rsync[0], rx};
      rx_valid <= 1'b0;
      if (tick) rtk <= rtk + 1'b1;
      unique case (rstate)
        R_IDLE: if (!rs) begin
          rtk    <= '0;
          rstate <= R_START;
        end
        R_START: if (rhalf) begin
          rtk    <= '0;
          rbit   <= '0;
          rstate <= rs ? R_IDLE : R_DATA;
        end
        R_DATA: if (rlast) begin
          rtk <= '0;
          rsh <= {rs, rsh[DATA_BITS-1:1]};
          if (rbit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            rstate <= R_PAR;
`else
            rstate <= R_STOP;
`endif
          end else begin
            rbit <= rbit + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        R_PAR: if (rlast) begin
          rtk    <= '0;
          rpe    <= rs ^ (^rsh) ^ ODD;
          rstate <= R_STOP;
        end
`endif
        // a low stop bit may be a break: hold off until the line idles
        R_STOP: if (rlast) begin
          rtk          <= '0;
          rx_data      <= rsh;
          rx_frame_err <= !rs;
          rx_valid     <= 1'b1;
`ifdef UART_PARITY_EN
          rx_parity_err <= rpe;
`endif
          rstate <= rs ? R_IDLE : R_WAIT;
        end
        R_WAIT: if (rs) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
